// File: rtl/adc_sample_averager.sv
// Block averager for the 8-bit ADC stage: sums 2^LOG2_N samples and emits the mean on valid/ready.
// Optional running block min/max outputs are compiled in with `define ADC_AVG_MINMAX_EN.
module adc_sample_averager #(
  parameter int LOG2_N = 3
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       rd_n_in,
  input  logic [7:0] adc_data,
  output logic [7:0] avg_data,
  output logic       avg_valid,
  input  logic       avg_ready,
  output logic       overrun,
  input  logic       clear_overrun
`ifdef ADC_AVG_MINMAX_EN
  ,
  output logic [7:0] min_data,
  output logic [7:0] max_data
`endif
);

  localparam int ACC_W = 8 + LOG2_N;
  localparam int CNT_W = LOG2_N + 1;
  localparam int N     = 1 << LOG2_N;

  typedef enum logic {IDLE, ACC} state_t;

  state_t           state;
  logic             rd_n_q;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic             strobe;
  logic             take;
  logic             last;
  logic             done;
  logic [ACC_W-1:0] sum;

  always_comb begin
    strobe = rd_n_in & ~rd_n_q;
    take   = (state == ACC) && enable && strobe;
    last   = (cnt == CNT_W'(N - 1));
    done   = take && last;
    sum    = acc + ACC_W'(adc_data);
  end

`ifdef ADC_AVG_MINMAX_EN
  logic [7:0] run_min;
  logic [7:0] run_max;
  logic [7:0] blk_min;
  logic [7:0] blk_max;

  // First sample of a block seeds both extremes.
  always_comb begin
    blk_min = adc_data;
    blk_max = adc_data;
    if (cnt != '0) begin
      blk_min = (adc_data < run_min) ? adc_data : run_min;
      blk_max = (adc_data > run_max) ? adc_data : run_max;
    end
  end
`endif

  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      state     <= IDLE;
      rd_n_q    <= 1'b1;
      acc       <= '0;
      cnt       <= '0;
      avg_data  <= '0;
      avg_valid <= 1'b0;
      overrun   <= 1'b0;
`ifdef ADC_AVG_MINMAX_EN
      run_min   <= '0;
      run_max   <= '0;
      min_data  <= '0;
      max_data  <= '0;
`endif
    end else begin
      rd_n_q <= rd_n_in;

      case (state)
        IDLE: begin
          acc <= '0;
          cnt <= '0;
          if (enable) state <= ACC;
        end
        ACC: begin
          if (!enable) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
          end else if (strobe) begin
            if (last) begin
              acc <= '0;
              cnt <= '0;
            end else begin
              acc <= sum;
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase

`ifdef ADC_AVG_MINMAX_EN
      if (take) begin
        run_min <= blk_min;
        run_max <= blk_max;
      end
`endif

      // A finished block replaces the result only if the slot is free or draining now.
      if (done && (!avg_valid || avg_ready)) begin
        avg_data  <= 8'(sum >> LOG2_N);
        avg_valid <= 1'b1;
`ifdef ADC_AVG_MINMAX_EN
        min_data  <= blk_min;
        max_data  <= blk_max;
`endif
      end else if (avg_valid && avg_ready) begin
        avg_valid <= 1'b0;
      end

      if (done && avg_valid && !avg_ready) overrun <= 1'b1;
      else if (clear_overrun)              overrun <= 1'b0;
    end
  end

endmodule
